// File: rtl/mem_stream_demux_pkg.sv
// stream_pkg: shared sizes, stream field positions and FSM state type for the
// merged-memory-stream receive side (mem_stream_demux and its item counters).
package stream_pkg;

    localparam int NMEM     = 12;  // destination memories, source index 0..NMEM-1
    localparam int DATA_W   = 44;  // payload width per memory word
    localparam int CNT_W    = 6;   // item counter / low write-address width
    localparam int BX_W     = 3;   // bunch-crossing field / high write-address width

    // Stream word layout
    localparam int STREAM_W = 48;
    localparam int IDX_HI   = 47;  // data word: source index [47:44]
    localparam int IDX_LO   = 44;
    localparam int IDX_W    = IDX_HI - IDX_LO + 1;
    localparam int BX_LO    = 0;   // header word: BX [BX_LO +: BX_W]

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stream_demux_counter.sv
// demux_item_counter: per-memory item counter for one bunch crossing.
//  clk, reset : clock, synchronous active-high reset
//  clr        : start of a new BX, zero count and overflow
//  inc        : a word for this memory arrived
//  cnt        : items written so far this BX (saturates at all-ones)
//  full       : count at capacity, the next word must be dropped
//  ovf        : sticky until clr/reset, a word was dropped this BX
module demux_item_counter
    import stream_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             ovf
);

    // Capacity is 2^CNT_W-1 so the final count always fits the field.
    assign full = &cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (full) ovf <= 1'b1;
            else      cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_stream_demux.sv
// mem_stream_demux: scatters words of the merged memory stream back into NMEM
// destination memories by source index and republishes per-memory item
// counts at every BX header. All outputs are registered, one cycle after input.
//  clk, reset     : clock, synchronous active-high reset
//  mem_dat_stream : data word {idx[47:44], payload[43:0]} or header {.., bx[2:0]}
//  valid, send_BX : word is data / word is a BX header
//  wr_en          : one-hot memory write enable
//  wr_addr,wr_dat : shared write bus, address {bx_cur, item count}
//  number_out     : item counts of last completed BX, mem i at [i*CNT_W +: CNT_W]
//  number_bx, done: BX of number_out, pulse when published
//  overflow       : per-memory sticky drop flag for the current BX
//  proto_err      : pulse on out-of-range index or valid & send_BX together
module mem_stream_demux
    import stream_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [STREAM_W-1:0]     mem_dat_stream,
    input  logic                    valid,
    input  logic                    send_BX,
    output logic [NMEM-1:0]         wr_en,
    output logic [BX_W+CNT_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]       wr_dat,
    output logic [NMEM*CNT_W-1:0]   number_out,
    output logic [BX_W-1:0]         number_bx,
    output logic                    done,
    output logic [NMEM-1:0]         overflow,
    output logic                    proto_err
);

    state_t                      state, state_nxt;
    logic [IDX_W-1:0]            idx;
    logic                        idx_ok, dat_run;
    logic [NMEM-1:0]             inc, full, wr_sel;
    logic [NMEM-1:0][CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]            sel_cnt;
    logic [BX_W-1:0]             bx_cur;

    assign idx     = mem_dat_stream[IDX_HI:IDX_LO];
    assign idx_ok  = int'(idx) < NMEM;
    // A data word colliding with a header is dropped, so only pure data counts.
    assign dat_run = valid & ~send_BX & (state == RUN);

    // Index decode; an out-of-range index matches no memory.
    always_comb begin
        inc     = '0;
        sel_cnt = '0;
        for (int i = 0; i < NMEM; i++) begin
            if (idx == IDX_W'(i)) begin
                inc[i]  = dat_run;
                sel_cnt = cnt[i];
            end
        end
    end

    assign wr_sel = inc & ~full;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (send_BX) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    genvar g;
    generate
        for (g = 0; g < NMEM; g++) begin : g_cnt
            demux_item_counter u_cnt (
                .clk   (clk),
                .reset (reset),
                .clr   (send_BX),
                .inc   (inc[g]),
                .cnt   (cnt[g]),
                .full  (full[g]),
                .ovf   (overflow[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_dat     <= '0;
            number_out <= '0;
            number_bx  <= '0;
            done       <= 1'b0;
            proto_err  <= 1'b0;
            bx_cur     <= '0;
        end else begin
            wr_en     <= wr_sel;
            done      <= send_BX & (state == RUN);
            proto_err <= (valid & send_BX) | (dat_run & ~idx_ok);
            if (|wr_sel) begin
                wr_addr <= {bx_cur, sel_cnt};
                wr_dat  <= mem_dat_stream[DATA_W-1:0];
            end
            if (send_BX) begin
                // The first header after IDLE has no completed BX to publish.
                if (state == RUN) begin
                    number_out <= cnt;
                    number_bx  <= bx_cur;
                end
                bx_cur <= mem_dat_stream[BX_LO +: BX_W];
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_demux.sv
module tb_mem_stream_demux;
    import stream_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [STREAM_W-1:0]   mem_dat_stream;
    logic                  valid, send_BX;
    logic [NMEM-1:0]       wr_en;
    logic [BX_W+CNT_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_dat;
    logic [NMEM*CNT_W-1:0] number_out;
    logic [BX_W-1:0]       number_bx;
    logic                  done;
    logic [NMEM-1:0]       overflow;
    logic                  proto_err;

    mem_stream_demux dut (
        .clk(clk), .reset(reset), .mem_dat_stream(mem_dat_stream),
        .valid(valid), .send_BX(send_BX), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_dat(wr_dat), .number_out(number_out), .number_bx(number_bx),
        .done(done), .overflow(overflow), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    cyc;
        int                    mem;
        logic [BX_W+CNT_W-1:0] addr;
        logic [DATA_W-1:0]     dat;
    } wr_t;
    typedef struct {
        int                    cyc;
        logic [NMEM*CNT_W-1:0] counts;
        logic [BX_W-1:0]       bx;
    } pub_t;

    wr_t  wrq[$];
    pub_t pubq[$];
    int   errq[$];

    int n_cmp = 0, n_bad = 0;
    int cyc_n = 0;
    bit started = 0;

    // Reference model: the memories' fill state per BX.
    int              mcnt[NMEM];
    logic [NMEM-1:0] mov = '0, exp_ovf = '0;
    logic [BX_W-1:0] mbx = '0;
    bit              mrun = 0;
    localparam int CAP = (1 << CNT_W) - 1;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [STREAM_W-1:0] mk(input int idx, input logic [DATA_W-1:0] pl);
        mk = {IDX_W'(idx), pl};
    endfunction
    function automatic logic [STREAM_W-1:0] hdr(input int bx);
        hdr = STREAM_W'(bx & 7);
    endfunction

    // Drive one cycle and predict what the DUT must show after the next edge.
    task automatic cyc(input bit r, input bit v, input bit s, input logic [STREAM_W-1:0] w);
        reset = r; valid = v; send_BX = s; mem_dat_stream = w;
        if (r) begin
            mrun = 0; mbx = '0; mov = '0;
            for (int i = 0; i < NMEM; i++) mcnt[i] = 0;
        end else if (s) begin
            if (v) errq.push_back(cyc_n + 1);
            if (mrun) begin
                pub_t p;
                p.cyc = cyc_n + 1;
                p.bx  = mbx;
                p.counts = '0;
                for (int i = 0; i < NMEM; i++) p.counts[i*CNT_W +: CNT_W] = CNT_W'(mcnt[i]);
                pubq.push_back(p);
            end
            for (int i = 0; i < NMEM; i++) mcnt[i] = 0;
            mov = '0; mbx = w[BX_W-1:0]; mrun = 1;
        end else if (v && mrun) begin
            int ix;
            ix = int'(w[IDX_HI:IDX_LO]);
            if (ix >= NMEM) errq.push_back(cyc_n + 1);
            else if (mcnt[ix] == CAP) mov[ix] = 1'b1;
            else begin
                wrq.push_back('{cyc_n + 1, ix, {mbx, CNT_W'(mcnt[ix])}, w[DATA_W-1:0]});
                mcnt[ix]++;
            end
        end
        @(posedge clk); #1;
        exp_ovf = mov;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0);
    endtask

    // Monitor: pops the scoreboard whenever an expected output is due.
    always @(negedge clk) if (started) begin
        bit ew, ep, ee;
        check("wr_onehot", 128'($countones(wr_en) <= 1), 128'(1));
        ew = wrq.size() > 0 && wrq[0].cyc == cyc_n;
        check("wr_present", 128'(wr_en != '0), 128'(ew));
        if (ew) begin
            wr_t w;
            w = wrq.pop_front();
            check("wr_en", 128'(wr_en), 128'(NMEM'(1) << w.mem));
            check("wr_addr", 128'(wr_addr), 128'(w.addr));
            check("wr_dat", 128'(wr_dat), 128'(w.dat));
        end
        ep = pubq.size() > 0 && pubq[0].cyc == cyc_n;
        check("done", 128'(done), 128'(ep));
        if (ep) begin
            pub_t p;
            p = pubq.pop_front();
            check("number_out", 128'(number_out), 128'(p.counts));
            check("number_bx", 128'(number_bx), 128'(p.bx));
        end
        ee = errq.size() > 0 && errq[0] == cyc_n;
        check("proto_err", 128'(proto_err), 128'(ee));
        if (ee) void'(errq.pop_front());
        check("overflow", 128'(overflow), 128'(exp_ovf));
    end

    initial begin
        for (int i = 0; i < NMEM; i++) mcnt[i] = 0;
        reset = 1; valid = 0; send_BX = 0; mem_dat_stream = '0;
        @(posedge clk); #1;
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        started = 1;
        check("rst_wr_en", 128'(wr_en), 0);
        check("rst_number_out", 128'(number_out), 0);
        check("rst_done", 128'(done), 0);
        check("rst_overflow", 128'(overflow), 0);

        // 1: data in IDLE is ignored
        cyc(0, 1, 0, mk(2, 44'h123));
        gap(2);
        check("idle_number_out", 128'(number_out), 0);

        // 2: basic scatter and publish
        cyc(0, 0, 1, hdr(5));
        cyc(0, 1, 0, mk(0, 44'hA));
        cyc(0, 1, 0, mk(0, 44'hB));
        cyc(0, 1, 0, mk(3, 44'hC));
        cyc(0, 0, 1, hdr(6));
        gap(2);
        check("t2_count0", 128'(number_out[0 +: CNT_W]), 2);
        check("t2_count3", 128'(number_out[3*CNT_W +: CNT_W]), 1);

        // 3: saturation of one memory
        cyc(0, 0, 1, hdr(1));
        for (int i = 0; i < 65; i++) cyc(0, 1, 0, mk(7, {12'h0, $urandom}));
        gap(1);
        check("t3_overflow7", 128'(overflow[7]), 1);
        cyc(0, 0, 1, hdr(2));
        gap(1);
        check("t3_count7", 128'(number_out[7*CNT_W +: CNT_W]), 63);
        check("t3_ovf_clear", 128'(overflow), 0);

        // 4: bad index, then header colliding with data
        cyc(0, 1, 0, mk(13, 44'h55));
        cyc(0, 1, 1, hdr(2) | mk(4, 44'h0));
        gap(2);

        // 5: reset mid-BX, BX wrap
        cyc(0, 0, 1, hdr(7));
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, mk(11, 44'(i + 1)));
        cyc(1, 0, 0, '0);
        cyc(0, 0, 1, hdr(0));
        gap(2);
        cyc(0, 0, 1, hdr(3));
        gap(2);
        check("t5_bx", 128'(number_bx), 0);
        check("t5_zero", 128'(number_out), 0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 1)       cyc(1, 0, 0, '0);
            else if (r < 8)  cyc(0, 0, 1, hdr(int'($urandom_range(0, 7))));
            else if (r < 10) cyc(0, 1, 1, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
            else if (r < 30) gap(1);
            else begin
                int ix;
                ix = (r < 34) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 3));
                cyc(0, 1, 0, mk(ix, {12'h0, $urandom}));
            end
        end
        gap(3);
        check("wrq_drained", 128'(wrq.size()), 0);
        check("pubq_drained", 128'(pubq.size()), 0);
        check("errq_drained", 128'(errq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
